// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {IDLE, GRANT} arb_state_t;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Beat counter width for a given burst limit, never narrower than one bit.
  function automatic int unsigned cnt_w(int unsigned max_burst);
    return (max_burst > 1) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write-port arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned MAX_BURST = 16
);
  import fifo_arb_pkg::*;

  localparam int unsigned IdxW = idx_w(NREQ);
  localparam int unsigned CntW = cnt_w(MAX_BURST);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mask;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic                  fifo_wr_full;
  logic                  grant_vld;
  logic [IdxW-1:0]       grant_id;
  logic [CntW-1:0]       beat_cnt;

  // Requesters plus the FIFO full flag drive this side.
  modport master (
    output req_valid, req_last, req_data, req_mask, fifo_wr_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id, beat_cnt
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_last, req_data, req_mask, fifo_wr_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_vld, grant_id, beat_cnt
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [IdxW-1:0] pos;
  logic            found;

  // Scan NREQ positions starting at ptr_i; the first hit wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    pos      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = IdxW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[pos]) begin
        found         = 1'b1;
        onehot_o[pos] = 1'b1;
        idx_o         = pos;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port among NREQ requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               wr_clk,
  input  logic               wr_rstb,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int unsigned IdxW  = idx_w(NREQ);
  localparam int unsigned CntW  = cnt_w(MAX_BURST);
  localparam int unsigned MaxM1 = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;

  arb_state_t      state_q, state_d;
  logic [IdxW-1:0] grant_id_q, grant_id_d;
  logic [NREQ-1:0] grant_oh_q, grant_oh_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  logic [NREQ-1:0] elig, pick_req, pick_oh;
  logic [IdxW-1:0] pick_ptr, pick_idx, ptr_nxt;
  logic            pick_any, accept, rel, hit_max;

  assign elig    = bus.req_valid & ~bus.req_mask;
  assign hit_max = (MAX_BURST != 0) && (beat_cnt_q == CntW'(MaxM1));
  assign accept  = (state_q == GRANT) && bus.req_valid[grant_id_q] && !bus.fifo_wr_full;
  assign rel     = accept && (bus.req_last[grant_id_q] || hit_max);
  assign ptr_nxt = (grant_id_q == IdxW'(NREQ - 1)) ? '0 : grant_id_q + IdxW'(1);

  // On release, re-arbitrate from the advanced pointer with the old owner forced out.
  always_comb begin
    pick_req = elig;
    pick_ptr = rr_ptr_q;
    if (rel) begin
      pick_req = elig & ~(NREQ'(1) << grant_id_q);
      pick_ptr = ptr_nxt;
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i    (pick_req),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Next-state: grant on any eligible request, hold through the burst, hand over on release.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    grant_oh_d = grant_oh_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          grant_id_d = pick_idx;
          grant_oh_d = pick_oh;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          rr_ptr_d   = ptr_nxt;
          beat_cnt_d = '0;
          if (pick_any) begin
            grant_id_d = pick_idx;
            grant_oh_d = pick_oh;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any burst in progress.
  always_ff @(posedge wr_clk or negedge wr_rstb) begin
    if (!wr_rstb) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      grant_oh_q <= grant_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Outputs: ready only to the owner and only while the FIFO has room; data zero when idle.
  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    if (state_q == GRANT && !bus.fifo_wr_full) begin
      bus.req_ready = grant_oh_q;
    end
    if (accept) begin
      bus.fifo_wr_en   = 1'b1;
      bus.fifo_wr_data = bus.req_data[grant_id_q*WIDTH +: WIDTH];
    end
  end

  assign bus.grant_vld = (state_q == GRANT);
  assign bus.grant_id  = grant_id_q;
  assign bus.beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a scoreboard of expected FIFO writes.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned MAX_BURST = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [1:0]       id;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic wr_clk;
  logic wr_rstb;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk  (wr_clk),
    .wr_rstb (wr_rstb),
    .bus     (bus)
  );

  beat_t           src_q [NREQ][$];
  exp_t            sb_q [$];
  logic [NREQ-1:0] mask_r;
  logic            full_r;
  int              checks;
  int              errors;

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [NREQ-1:0]       v;
    logic [NREQ-1:0]       l;
    logic [NREQ*WIDTH-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        v[i]                = 1'b1;
        l[i]                = src_q[i][0].last;
        d[i*WIDTH +: WIDTH] = src_q[i][0].data;
      end
    end
    bus.req_valid    = v;
    bus.req_last     = l;
    bus.req_data     = d;
    bus.req_mask     = mask_r;
    bus.fifo_wr_full = full_r;
  endtask

  task automatic sample();
    exp_t e;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) void'(src_q[i].pop_front());
    end
    chk("wr_while_full", 64'(bus.fifo_wr_en & bus.fifo_wr_full), 64'd0);
    if (bus.fifo_wr_en) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        chk("wr_id", 64'(bus.grant_id), 64'(e.id));
        chk("wr_data", 64'(bus.fifo_wr_data), 64'(e.data));
      end
    end else begin
      chk("idle_data", 64'(bus.fifo_wr_data), 64'd0);
    end
  endtask

  // One clock: drive just after the edge, check at the falling edge.
  task automatic cyc();
    @(posedge wr_clk);
    #1 drive();
    @(negedge wr_clk);
    sample();
  endtask

  task automatic load(input int id, input int n, input logic [WIDTH-1:0] base, input bit last_en);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + WIDTH'(k);
      b.last = last_en && (k == n - 1);
      src_q[id].push_back(b);
    end
  endtask

  task automatic expect_beats(input int id, input int n, input logic [WIDTH-1:0] base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = 2'(id);
      e.data = base + WIDTH'(k);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < limit) begin
      cyc();
      k++;
    end
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_grant_vld"}, 64'(bus.grant_vld), 64'd0);
    chk({tag, "_grant_id"}, 64'(bus.grant_id), 64'd0);
    chk({tag, "_beat_cnt"}, 64'(bus.beat_cnt), 64'd0);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    chk({tag, "_wr_en"}, 64'(bus.fifo_wr_en), 64'd0);
    chk({tag, "_wr_data"}, 64'(bus.fifo_wr_data), 64'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    mask_r  = '0;
    full_r  = 1'b0;
    wr_rstb = 1'b0;
    drive();
    repeat (2) @(negedge wr_clk);
    rst_check("reset");
    wr_rstb = 1'b1;

    // Single requester, 3-beat burst.
    load(0, 3, 32'hA000_0000, 1'b1);
    expect_beats(0, 3, 32'hA000_0000);
    cyc();
    chk("t1_latency", 64'(bus.grant_vld), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t1_grant_id", 64'(bus.grant_id), 64'd0);
      chk("t1_beat_cnt", 64'(bus.beat_cnt), 64'(k));
      chk("t1_wr_en", 64'(bus.fifo_wr_en), 64'd1);
    end
    cyc();
    chk("t1_released", 64'(bus.grant_vld), 64'd0);

    // Reset back to rr_ptr 0, then all four with two 2-beat bursts each.
    wr_rstb = 1'b0;
    #1 rst_check("rst2");
    #1 wr_rstb = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        load(i, 2, 32'hB000_0000 + 32'(i << 8) + 32'(r << 4), 1'b1);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        expect_beats(i, 2, 32'hB000_0000 + 32'(i << 8) + 32'(r << 4));
      end
    end
    cyc();
    chk("t2_latency", 64'(bus.grant_vld), 64'd0);
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("t2_no_gap", 64'(bus.fifo_wr_en), 64'd1);
    end
    cyc();
    chk("t2_released", 64'(bus.grant_vld), 64'd0);

    // Burst limit: req1 never signals last.
    load(1, 8, 32'hC000_0000, 1'b0);
    expect_beats(1, 8, 32'hC000_0000);
    cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3_beat_cnt", 64'(bus.beat_cnt), 64'(k));
      chk("t3_grant_id", 64'(bus.grant_id), 64'd1);
    end
    cyc();
    chk("t3_idle_gap", 64'(bus.grant_vld), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3_regrant_cnt", 64'(bus.beat_cnt), 64'(k));
      chk("t3_regrant_id", 64'(bus.grant_id), 64'd1);
    end
    cyc();
    chk("t3_released", 64'(bus.grant_vld), 64'd0);

    // Burst limit hands over straight to req2.
    load(1, 4, 32'hC100_0000, 1'b0);
    expect_beats(1, 4, 32'hC100_0000);
    expect_beats(2, 1, 32'hC200_0000);
    cyc();
    cyc();
    load(2, 1, 32'hC200_0000, 1'b1);
    repeat (3) cyc();
    cyc();
    chk("t3_b2b_id", 64'(bus.grant_id), 64'd2);
    chk("t3_b2b_wr", 64'(bus.fifo_wr_en), 64'd1);
    cyc();
    chk("t3b_released", 64'(bus.grant_vld), 64'd0);

    // FIFO full stall mid-burst of req2.
    load(2, 4, 32'hD000_0000, 1'b1);
    expect_beats(2, 4, 32'hD000_0000);
    cyc();
    cyc();
    full_r = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t4_ready", 64'(bus.req_ready), 64'd0);
      chk("t4_wr_en", 64'(bus.fifo_wr_en), 64'd0);
      chk("t4_grant_id", 64'(bus.grant_id), 64'd2);
      chk("t4_grant_vld", 64'(bus.grant_vld), 64'd1);
      chk("t4_beat_cnt", 64'(bus.beat_cnt), 64'd1);
    end
    full_r = 1'b0;
    drain(10);
    cyc();
    chk("t4_released", 64'(bus.grant_vld), 64'd0);

    // Masked requester is never granted; masking the owner does not cut its burst.
    mask_r = 4'b0010;
    load(1, 2, 32'hE100_0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t5_masked", 64'(bus.grant_vld), 64'd0);
    end
    load(3, 3, 32'hE300_0000, 1'b1);
    expect_beats(3, 3, 32'hE300_0000);
    expect_beats(1, 2, 32'hE100_0000);
    cyc();
    cyc();
    chk("t5_owner", 64'(bus.grant_id), 64'd3);
    mask_r = 4'b1010;
    repeat (2) cyc();
    cyc();
    chk("t5_owner_done", 64'(sb_q.size()), 64'd2);
    chk("t5_all_masked", 64'(bus.grant_vld), 64'd0);
    mask_r = '0;
    drain(10);
    cyc();
    chk("t5_released", 64'(bus.grant_vld), 64'd0);

    // Asynchronous reset at beat 3 of a 6-beat burst.
    load(0, 6, 32'hF000_0000, 1'b1);
    expect_beats(0, 3, 32'hF000_0000);
    cyc();
    repeat (3) cyc();
    @(posedge wr_clk);
    #1 drive();
    #2;
    chk("t6_beat3_cnt", 64'(bus.beat_cnt), 64'd3);
    chk("t6_beat3_wr", 64'(bus.fifo_wr_en), 64'd1);
    wr_rstb = 1'b0;
    #1 rst_check("t6_async");
    src_q[0].delete();
    drive();
    @(negedge wr_clk);
    wr_rstb = 1'b1;
    load(1, 1, 32'hF100_0000, 1'b1);
    load(3, 1, 32'hF300_0000, 1'b1);
    expect_beats(1, 1, 32'hF100_0000);
    expect_beats(3, 1, 32'hF300_0000);
    drain(10);

    for (int i = 0; i < NREQ; i++) begin
      chk("src_empty", 64'(src_q[i].size()), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
